// File: rtl/wbm_spi_pkg.sv
// wbm_spi_pkg: definitions shared by the SPI-to-Wishbone bridge.
//   - state_e         : controller FSM states
//   - STATUS_*        : status byte codes returned to the SPI host
//   - CMD_*           : bit positions inside the command byte
//   - term_status()   : maps a bus termination to its status code
package wbm_spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WDATA    = 3'd1,
    BUS      = 3'd2,
    RESP_ST  = 3'd3,
    RESP_DAT = 3'd4
  } state_e;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BUSERR  = 8'hE1;
  localparam logic [7:0] STATUS_TIMEOUT = 8'hE2;

  localparam int CMD_WE_BIT  = 7;
  localparam int CMD_ADR_MSB = 6;

  // err dominates ack when both are sampled high in the same cycle;
  // with neither present the only remaining cause is the timeout.
  function automatic logic [7:0] term_status(input logic ack, input logic err);
    if (err)      return STATUS_BUSERR;
    else if (ack) return STATUS_OK;
    else          return STATUS_TIMEOUT;
  endfunction

endpackage

// File: rtl/wbm_spi_timer.sv
// wbm_spi_timer: bus-cycle watchdog.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : forces the count to zero
//   en_i       : counts one BUS cycle
//   expired_o  : high in the TIMEOUT-th enabled cycle after a clear
module wbm_spi_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clear_i) begin
      cnt_q <= 8'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Combinational so the abort happens in the same edge the count is reached.
  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wbm_spi_ctrl.sv
// wbm_spi_ctrl: turns SPI command bytes into single Wishbone classic cycles
// and returns a status byte (plus read data for successful reads).
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_ready : incoming SPI bytes (command, optional data)
//   tx_valid/tx_data/tx_ready : outgoing response bytes
//   wb_*                  : Wishbone classic master port
module wbm_spi_ctrl
  import wbm_spi_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [6:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       wb_err_i
);

  state_e     state_q;
  logic       rx_ready_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       cyc_q;
  logic       we_q;
  logic [6:0] adr_q;
  logic [7:0] dat_q;
  logic [7:0] rd_q;
  logic       tmr_expired;

  // Counter is held at zero outside BUS, so every BUS entry starts from zero.
  wbm_spi_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q != BUS),
    .en_i      (state_q == BUS),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 7'd0;
      dat_q      <= 8'd0;
      rd_q       <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_valid && rx_ready_q) begin
            we_q  <= rx_data[CMD_WE_BIT];
            adr_q <= rx_data[CMD_ADR_MSB:0];
            if (rx_data[CMD_WE_BIT]) begin
              state_q <= WDATA;
            end else begin
              state_q    <= BUS;
              cyc_q      <= 1'b1;
              rx_ready_q <= 1'b0;
            end
          end
        end
        WDATA: begin
          if (rx_valid && rx_ready_q) begin
            dat_q      <= rx_data;
            state_q    <= BUS;
            cyc_q      <= 1'b1;
            rx_ready_q <= 1'b0;
          end
        end
        BUS: begin
          if (wb_ack_i || wb_err_i || tmr_expired) begin
            cyc_q      <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= term_status(wb_ack_i, wb_err_i);
            state_q    <= RESP_ST;
            if (wb_ack_i && !wb_err_i && !we_q) begin
              rd_q <= wb_dat_i;
            end
          end
        end
        RESP_ST: begin
          if (tx_ready) begin
            // tx_data_q still holds the status byte here.
            if (!we_q && (tx_data_q == STATUS_OK)) begin
              tx_data_q <= rd_q;
              state_q   <= RESP_DAT;
            end else begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        RESP_DAT: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          cyc_q      <= 1'b0;
          tx_valid_q <= 1'b0;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// tb_wbm_spi_ctrl: randomized bench for wbm_spi_ctrl with a transaction-level
// model: each command yields an expected bus access, bus-cycle count and
// response byte list, compared against what the DUT actually does.
module tb_wbm_spi_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [6:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  wbm_spi_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave. lat = BUS-cycle index of
  // the termination. txstall = cycles tx_ready is held low per response byte.
  task automatic run_cmd(input logic we, input logic [6:0] adr, input logic [7:0] wdat,
                         input int mode, input int lat, input logic [7:0] rdat,
                         input int txstall, input bit hold_next);
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    logic [7:0] status, prev_txd, exp_b;
    bit   timeout_case, rx_fire, tx_fire, prev_txv, prev_fire, done;
    int   exp_bus, exp_total, bus_n, first_bus, last_bus, last_rx, first_txv, got_n, stall;

    rxq.push_back({we, adr});
    if (we) rxq.push_back(wdat);
    timeout_case = (mode == 3) || (lat >= TO);
    status    = timeout_case ? 8'hE2 : ((mode == 0) ? 8'h00 : 8'hE1);
    exp_bus   = timeout_case ? TO : lat + 1;
    expq.push_back(status);
    if (!we && status == 8'h00) expq.push_back(rdat);
    exp_total = expq.size();

    bus_n = 0; first_bus = -1; last_bus = -1; last_rx = -1; first_txv = -1; got_n = 0;
    stall = txstall; prev_txv = 0; prev_fire = 0; prev_txd = 8'h00; done = 0;

    for (int c = 0; c < 300 && !done; c++) begin
      if (rxq.size() > 0) begin
        rx_valid = 1'b1;
        rx_data  = rxq[0];
      end else begin
        rx_valid = hold_next;
        rx_data  = 8'h00;
        chk("rx_ready_busy", rx_ready, 0);
      end

      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 8'($urandom);
      if (wb_cyc_o) begin
        if (first_bus < 0) begin
          first_bus = cyc_n;
          chk("bus_latency", first_bus, last_rx + 1);
        end
        chk("stb", wb_stb_o, 1);
        chk("we", wb_we_o, we);
        chk("adr", wb_adr_o, adr);
        if (we) chk("dat_o", wb_dat_o, wdat);
        if (mode != 3 && bus_n == lat) begin
          wb_ack_i = (mode != 1);
          wb_err_i = (mode != 0);
          wb_dat_i = rdat;
        end
        bus_n++;
        last_bus = cyc_n;
      end

      if (tx_valid) begin
        if (first_txv < 0) begin
          first_txv = cyc_n;
          chk("resp_latency", first_txv, last_bus + 1);
        end
        if (prev_txv && !prev_fire) chk("tx_stable", tx_data, prev_txd);
        if (stall > 0) begin
          tx_ready = 1'b0;
          stall--;
        end else begin
          tx_ready = 1'b1;
        end
      end else begin
        if (prev_txv && !prev_fire) chk("tx_valid_held", tx_valid, 1);
        tx_ready = 1'($urandom_range(0, 1));
      end

      rx_fire   = rx_valid && rx_ready;
      tx_fire   = tx_valid && tx_ready;
      prev_txv  = tx_valid;
      prev_txd  = tx_data;
      prev_fire = tx_fire;
      step();

      if (rx_fire && rxq.size() > 0) begin
        void'(rxq.pop_front());
        last_rx = cyc_n - 1;
      end
      if (tx_fire) begin
        got_n++;
        if (expq.size() > 0) begin
          exp_b = expq.pop_front();
          chk("tx_byte", prev_txd, exp_b);
        end else begin
          chk("tx_count", got_n, exp_total);
        end
        stall = txstall;
        if (expq.size() == 0) done = 1;
      end
    end

    chk("txn_done", done, 1);
    chk("bus_cycles", bus_n, exp_bus);

    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_txv", tx_valid, 0);
      chk("idle_cyc", wb_cyc_o, 0);
      chk("idle_rx_ready", rx_ready, 1);
    end
  endtask

  task automatic reset_mid_bus();
    int w;
    rx_valid = 1'b1;
    rx_data  = 8'h12;
    tx_ready = 1'b1;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    step();
    rx_valid = 1'b0;
    w = 0;
    while (!wb_cyc_o && w < 10) begin
      step();
      w++;
    end
    chk("rst_reach_bus", wb_cyc_o, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_rx_ready_low", rx_ready, 0);
    step();
    chk("rst_rel_rx_ready_high", rx_ready, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rst_no_tx", tx_valid, 0);
      chk("rst_no_cyc", wb_cyc_o, 0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    wb_dat_i = 8'h00;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_cyc", wb_cyc_o, 0);
    chk("reset_stb", wb_stb_o, 0);
    chk("reset_we", wb_we_o, 0);
    chk("reset_adr", wb_adr_o, 0);
    chk("reset_dat_o", wb_dat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_rx_ready_low", rx_ready, 0);
    step();
    chk("release_rx_ready_high", rx_ready, 1);

    // Directed scenarios.
    run_cmd(1'b1, 7'h05, 8'h3C, 0, 2, 8'h00, 0, 1'b0);  // write, ack after 2
    run_cmd(1'b0, 7'h12, 8'h00, 0, 1, 8'hA7, 0, 1'b0);  // read 0xA7
    run_cmd(1'b0, 7'h01, 8'h00, 3, 0, 8'h00, 0, 1'b0);  // silent slave -> timeout
    run_cmd(1'b0, 7'h33, 8'h00, 0, 0, 8'h5A, 0, 1'b0);  // next command is normal
    run_cmd(1'b1, 7'h10, 8'h55, 2, 1, 8'h00, 0, 1'b0);  // ack+err -> bus error
    run_cmd(1'b0, 7'h44, 8'h00, 0, 0, 8'hC3, 20, 1'b1); // tx backpressure, rx pending
    run_cmd(1'b0, 7'h45, 8'h00, 0, TO - 1, 8'h99, 0, 1'b0); // ack in last allowed cycle

    reset_mid_bus();
    run_cmd(1'b0, 7'h7F, 8'h00, 0, 0, 8'h81, 1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom), 7'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, TO + 2)), 8'($urandom), int'($urandom_range(0, 4)),
              1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
